// File: rtl/shift_seq.sv
// Sequential controller that loops a 3-bit shift-by-one stage: accepts an operand
// and shift amount, shifts one position per clock, and returns the result.
module shift_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_data,
    input  logic [2:0] in_amount,
    output logic       sh_s,
    output logic [2:0] sh_inp,
    input  logic [2:0] sh_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_data,
    output logic       out_zero,
    output logic [2:0] out_shifts,
    output logic [1:0] o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready depends only on state and rst_n; out_valid only on state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_data;
    logic [2:0] r_count;
    logic [2:0] r_done_cnt;
    logic       w_accept;
    logic       w_last_shift;

    assign w_accept     = (r_state == IDLE) && in_valid;
    // Once the operand becomes zero, further shifts cannot change it.
    assign w_last_shift = (r_count == 3'd1) || (sh_out == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = (in_amount != 3'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= 3'd0;
            r_count    <= 3'd0;
            r_done_cnt <= 3'd0;
        end else if (w_accept) begin
            r_data     <= in_data;
            r_count    <= in_amount;
            r_done_cnt <= 3'd0;
        end else if (r_state == SHIFT) begin
            r_data     <= sh_out;
            r_count    <= r_count - 3'd1;
            r_done_cnt <= r_done_cnt + 3'd1;
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        sh_s       = 1'b0;
        sh_inp     = r_data;
        out_valid  = 1'b0;
        out_data   = 3'd0;
        out_zero   = 1'b0;
        out_shifts = 3'd0;
        case (r_state)
            IDLE:  in_ready = rst_n;
            SHIFT: sh_s = 1'b1;
            DONE: begin
                out_valid  = 1'b1;
                out_data   = r_data;
                out_zero   = (r_data == 3'd0);
                out_shifts = r_done_cnt;
            end
            default: ;
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural shift-by-one stage in the loop.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic [2:0] in_amount;
    logic       sh_s;
    logic [2:0] sh_inp;
    logic [2:0] sh_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       out_zero;
    logic [2:0] out_shifts;
    logic [1:0] dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] exp_q[$];
    logic [2:0] sh_seq[8];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Shift-by-one stage: logical left when s=1, pass-through otherwise.
    assign sh_out = sh_s ? {sh_inp[1:0], 1'b0} : sh_inp;

    shift_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .sh_s        (sh_s),
        .sh_inp      (sh_inp),
        .sh_out      (sh_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_zero    (out_zero),
        .out_shifts  (out_shifts),
        .o_dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // One transaction: accept, wait for result, optionally hold out_ready low
    // while presenting the (ignored) follow-up request 010/1, then release.
    task automatic run_txn(input logic [2:0] din, input logic [2:0] amt,
                           input logic [2:0] exp_data, input int exp_shifts,
                           input int exp_lat, input int hold);
        int         n;
        int         lat;
        int         shc;
        logic [2:0] want;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        exp_q.push_back(exp_data);
        in_valid  = 1'b1;
        in_data   = din;
        in_amount = amt;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        in_data   = 3'b111;
        in_amount = 3'b111;
        lat = 0;
        shc = 0;
        while (!out_valid && lat < 20) begin
            if (sh_s) begin
                if (shc < 8) sh_seq[shc] = sh_inp;
                shc++;
            end
            tick();
            lat++;
        end
        check("out_valid_latency", lat, exp_lat);
        check("sh_s_cycles", shc, exp_shifts);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        check("out_data", out_data, want);
        check("out_zero", out_zero, (want == 3'd0) ? 1 : 0);
        check("out_shifts", out_shifts, exp_shifts);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_data   = 3'b010;
            in_amount = 3'd1;
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, want);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (hold == 0) in_valid = 1'b0;
        check("post_release_out_valid", out_valid, 0);
        check("post_release_in_ready", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 3'b011;
        in_amount = 3'd3;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sh_s", sh_s, 0);
        check("rst_sh_inp", sh_inp, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_shifts", out_shifts, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        tick();

        run_txn(3'b011, 3'd1, 3'b110, 1, 1, 0);
        run_txn(3'b101, 3'd0, 3'b101, 0, 0, 0);
        run_txn(3'b001, 3'd7, 3'b000, 3, 3, 0);
        check("seq0", sh_seq[0], 3'b001);
        check("seq1", sh_seq[1], 3'b010);
        check("seq2", sh_seq[2], 3'b100);
        run_txn(3'b000, 3'd5, 3'b000, 1, 1, 0);
        // Backpressure: release edge also sees in_valid, which must wait a cycle.
        run_txn(3'b111, 3'd2, 3'b100, 2, 2, 4);
        run_txn(3'b010, 3'd1, 3'b100, 1, 1, 0);

        // Reset while shifting.
        in_valid  = 1'b1;
        in_data   = 3'b001;
        in_amount = 3'd2;
        tick();
        in_valid = 1'b0;
        check("mid_shift_sh_s_before_reset", sh_s, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_sh_s", sh_s, 0);
        check("mid_rst_sh_inp", sh_inp, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_rst_out_valid", out_valid, 0);
            check("after_rst_sh_s", sh_s, 0);
        end
        check("after_rst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Sequential controller that sits directly upstream of the 3-bit shift-by-one stage (`shifter`) and closes the loop around it. It accepts a 3-bit operand and a left-shift amount 0..7 over a valid/ready handshake. It then drives the shifter one position per clock, registering the shifter's output back as the next operand. It presents the final value on an output valid/ready handshake, with an all-zero flag and a count of shifts actually performed.

## Interface
- No parameters. Data width is fixed at 3 to match `shifter`.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept; high only in IDLE with `rst_n`=1
- `in_data`  in  3  operand, captured on accept
- `in_amount`  in  3  requested left-shift count 0..7, captured on accept
- `sh_s`  out  1  to `shifter.s`; 1 only in SHIFT
- `sh_inp`  out  3  to `shifter.inp`; always equals internal operand register
- `sh_out`  in  3  from `shifter.out`
- `out_valid`  out  1  result present; high only in DONE
- `out_ready`  in  1  consumer takes result
- `out_data`  out  3  result operand
- `out_zero`  out  1  `out_data`==000; meaningful while `out_valid`=1
- `out_shifts`  out  3  number of shift edges actually performed

## Operation
- Registers: `state` (IDLE/SHIFT/DONE), `data`[2:0], `count`[2:0] (shifts remaining), `done_cnt`[2:0] (shifts performed).
- IDLE: `in_ready`=1.
  - On an edge with `in_valid`=1, the block accepts: `data`<=`in_data`, `count`<=`in_amount`, `done_cnt`<=0.
  - After accept, go to SHIFT if `in_amount`!=0, otherwise go to DONE.
- SHIFT: `sh_s`=1, `sh_inp`=`data`. Each edge:
  - `data`<=`sh_out`, `count`<=`count`-1, `done_cnt`<=`done_cnt`+1.
  - Go to DONE if `count`==1 or `sh_out`==000 (early exit: further shifts cannot change the value). Otherwise stay in SHIFT.
- DONE: `out_valid`=1, `out_data`=`data`, `out_zero`=(`data`==0), `out_shifts`=`done_cnt`.
  - On an edge with `out_ready`=1, go to IDLE.
  - Hold all outputs stable while `out_ready`=0.
- `in_valid` is ignored outside IDLE. `in_data`/`in_amount` are sampled only on the accept edge.
- Arithmetic: shift is logical left. Bits shifted past bit 2 are lost and bit 0 fills with 0. `count` never underflows: SHIFT is entered only with `count`>=1.
- Reset: any edge with `rst_n`=0 forces IDLE with `data`=0, `count`=0, `done_cnt`=0. This discards any in-flight or pending result.
- Reset values of outputs: `in_ready`=0 while `rst_n`=0, then 1; `sh_s`=0; `sh_inp`=000; `out_valid`=0; `out_data`=000; `out_zero`=0; `out_shifts`=000.
  - Outside DONE, `out_data` is forced to 000, `out_zero` to 0 and `out_shifts` to 000.

## Timing
- E0 = accept edge.
  - `in_amount`=0: `out_valid` high from E0.
  - `in_amount`=N>=1 with no early exit: `out_valid` high from E0+N. `sh_s` is high for exactly N cycles.
  - Early exit: `out_valid` high from the first SHIFT edge whose `sh_out` is 000.
- The `shifter` path is purely combinational from `sh_inp`/`sh_s` to `sh_out`. `sh_out` is sampled on the same edge.
- No back-to-back overlap. The release edge (`out_ready`=1 in DONE) returns to IDLE, and `in_ready` rises in the cycle after it. The earliest next accept is one edge after release.
- `out_valid` falls the cycle after the release edge.
- Simultaneous `in_valid` and `out_ready` in DONE: only the release takes effect; the request waits.
- Reset takes priority over every transition, including accept and release on the same edge.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `sh_s`=0, `sh_inp`=000. After release: `in_ready`=1.
- Operand 011, amount 1, `out_ready`=1 -> `sh_s` high 1 cycle; `out_valid` from E0+1 with `out_data`=110, `out_zero`=0, `out_shifts`=1.
- Operand 101, amount 0 -> `sh_s` never high; `out_valid` from E0 with `out_data`=101, `out_shifts`=0.
- Operand 001, amount 7 -> `sh_inp` sequence 001, 010, 100; early exit; `out_valid` from E0+3 with `out_data`=000, `out_zero`=1, `out_shifts`=3. Operand 000, amount 5 -> `out_valid` from E0+1, `out_shifts`=1.
- Backpressure: operand 111, amount 2, `out_ready`=0 for 4 cycles -> `out_data`=100 held stable and `in_valid` ignored. After `out_ready`=1: `in_ready`=1 the next cycle and a second request (010, 1) returns 100.
- Reset mid-SHIFT: operand 001, amount 2, `rst_n`=0 at E0+1 -> IDLE, `out_valid` never asserts, `sh_s`=0, `sh_inp`=000.
